// File: rtl/axi4_arb_pkg.sv
// Shared widths, port index type and round-robin pick helper for the 2:1 AXI4 arbiter.
package axi4_arb_pkg;

    localparam int ADDR_W  = 32;
    localparam int ID_W    = 4;
    localparam int LEN_W   = 8;
    localparam int BURST_W = 2;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int RESP_W  = 2;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // A lone requester always wins; contention is settled by the round-robin pointer.
    function automatic port_e rr_pick(input logic req0, input logic req1, input port_e ptr);
        port_e pick;
        if (req0 && req1) begin
            pick = ptr;
        end else if (req1) begin
            pick = PORT1;
        end else begin
            pick = PORT0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/axi4_arb_if.sv
// One AXI4 port (AW/W/B/AR/R); master drives commands and data, slave drives responses.
interface axi4_arb_if;
    import axi4_arb_pkg::*;

    logic               awvalid;
    logic [ADDR_W-1:0]  awaddr;
    logic [ID_W-1:0]    awid;
    logic [LEN_W-1:0]   awlen;
    logic [BURST_W-1:0] awburst;
    logic               awready;
    logic               wvalid;
    logic [DATA_W-1:0]  wdata;
    logic [STRB_W-1:0]  wstrb;
    logic               wlast;
    logic               wready;
    logic               bvalid;
    logic [RESP_W-1:0]  bresp;
    logic [ID_W-1:0]    bid;
    logic               bready;
    logic               arvalid;
    logic [ADDR_W-1:0]  araddr;
    logic [ID_W-1:0]    arid;
    logic [LEN_W-1:0]   arlen;
    logic [BURST_W-1:0] arburst;
    logic               arready;
    logic               rvalid;
    logic [DATA_W-1:0]  rdata;
    logic [RESP_W-1:0]  rresp;
    logic [ID_W-1:0]    rid;
    logic               rlast;
    logic               rready;

    modport master (
        output awvalid, awaddr, awid, awlen, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input  bvalid, bresp, bid, output bready,
        output arvalid, araddr, arid, arlen, arburst, input arready,
        input  rvalid, rdata, rresp, rid, rlast, output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awburst, output awready,
        input  wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bresp, bid, input bready,
        input  arvalid, araddr, arid, arlen, arburst, output arready,
        output rvalid, rdata, rresp, rid, rlast, input rready
    );

endinterface

// File: rtl/axi4_arb_route_fifo.sv
// 1-bit route FIFO recording which upstream port owns each outstanding burst.
module axi4_arb_route_fifo #(
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int SLOTS = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [SLOTS-1:0]  mem_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (count_r == FULL_COUNT);
    assign empty     = (count_r == {(ADDR_W + 1){1'b0}});
    assign head      = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop & ~empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign push_ok_s = push & (~full | pop_ok_s);

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_r    <= {SLOTS{1'b0}};
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {(ADDR_W + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + ADDR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (ADDR_W + 1)'(1);
                2'b01:   count_r <= count_r - (ADDR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/axi4_arb.sv
// 2:1 AXI4 arbiter: round-robin AW and AR grants, W/B/R steered by grant-order route FIFOs.
module axi4_arb
    import axi4_arb_pkg::*;
#(
    parameter int OUTSTANDING_W = 4,
    parameter int OUTSTANDING_R = 4,
    parameter int FIFO_ADDR_W   = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    axi4_arb_if.slave  inport0,
    axi4_arb_if.slave  inport1,
    axi4_arb_if.master outport
);

    logic  live_s;
    port_e aw_grant_s, aw_grant_r, aw_ptr_r;
    port_e ar_grant_s, ar_grant_r, ar_ptr_r;
    logic  aw_lock_r, ar_lock_r;
    logic  aw_room_s, ar_room_s, aw_fire_s, ar_fire_s;
    logic  w_full_s, w_empty_s, w_head_s, w_pop_s;
    logic  b_full_s, b_empty_s, b_head_s, b_pop_s;
    logic  r_full_s, r_empty_s, r_head_s, r_pop_s;

    // Outputs are forced low while reset is asserted, independent of the clock.
    assign live_s    = ~rst_i;
    assign aw_room_s = ~w_full_s & ~b_full_s;
    assign ar_room_s = ~r_full_s;
    assign aw_fire_s = outport.awvalid & outport.awready;
    assign ar_fire_s = outport.arvalid & outport.arready;

    // AW grant: the locked owner keeps the channel until its handshake.
    always_comb begin
        aw_grant_s = PORT0;
        if (aw_lock_r) begin
            aw_grant_s = aw_grant_r;
        end else begin
            aw_grant_s = rr_pick(inport0.awvalid, inport1.awvalid, aw_ptr_r);
        end
    end

    // AR grant, same policy with its own lock and pointer.
    always_comb begin
        ar_grant_s = PORT0;
        if (ar_lock_r) begin
            ar_grant_s = ar_grant_r;
        end else begin
            ar_grant_s = rr_pick(inport0.arvalid, inport1.arvalid, ar_ptr_r);
        end
    end

    // AW lock and round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_lock_r  <= 1'b0;
            aw_grant_r <= PORT0;
            aw_ptr_r   <= PORT0;
        end else if (aw_fire_s) begin
            aw_lock_r  <= 1'b0;
            aw_grant_r <= aw_grant_s;
            aw_ptr_r   <= (aw_grant_s == PORT0) ? PORT1 : PORT0;
        end else if (outport.awvalid) begin
            aw_lock_r  <= 1'b1;
            aw_grant_r <= aw_grant_s;
        end
    end

    // AR lock and round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ar_lock_r  <= 1'b0;
            ar_grant_r <= PORT0;
            ar_ptr_r   <= PORT0;
        end else if (ar_fire_s) begin
            ar_lock_r  <= 1'b0;
            ar_grant_r <= ar_grant_s;
            ar_ptr_r   <= (ar_grant_s == PORT0) ? PORT1 : PORT0;
        end else if (outport.arvalid) begin
            ar_lock_r  <= 1'b1;
            ar_grant_r <= ar_grant_s;
        end
    end

    assign outport.awvalid = live_s & aw_room_s &
                             ((aw_grant_s == PORT1) ? inport1.awvalid : inport0.awvalid);
    assign outport.awaddr  = (aw_grant_s == PORT1) ? inport1.awaddr  : inport0.awaddr;
    assign outport.awid    = (aw_grant_s == PORT1) ? inport1.awid    : inport0.awid;
    assign outport.awlen   = (aw_grant_s == PORT1) ? inport1.awlen   : inport0.awlen;
    assign outport.awburst = (aw_grant_s == PORT1) ? inport1.awburst : inport0.awburst;
    assign inport0.awready = live_s & aw_room_s & (aw_grant_s == PORT0) & outport.awready;
    assign inport1.awready = live_s & aw_room_s & (aw_grant_s == PORT1) & outport.awready;

    assign outport.arvalid = live_s & ar_room_s &
                             ((ar_grant_s == PORT1) ? inport1.arvalid : inport0.arvalid);
    assign outport.araddr  = (ar_grant_s == PORT1) ? inport1.araddr  : inport0.araddr;
    assign outport.arid    = (ar_grant_s == PORT1) ? inport1.arid    : inport0.arid;
    assign outport.arlen   = (ar_grant_s == PORT1) ? inport1.arlen   : inport0.arlen;
    assign outport.arburst = (ar_grant_s == PORT1) ? inport1.arburst : inport0.arburst;
    assign inport0.arready = live_s & ar_room_s & (ar_grant_s == PORT0) & outport.arready;
    assign inport1.arready = live_s & ar_room_s & (ar_grant_s == PORT1) & outport.arready;

    // W follows the oldest un-drained AW grant.
    assign outport.wvalid = live_s & ~w_empty_s & (w_head_s ? inport1.wvalid : inport0.wvalid);
    assign outport.wdata  = w_head_s ? inport1.wdata : inport0.wdata;
    assign outport.wstrb  = w_head_s ? inport1.wstrb : inport0.wstrb;
    assign outport.wlast  = w_head_s ? inport1.wlast : inport0.wlast;
    assign inport0.wready = live_s & ~w_empty_s & ~w_head_s & outport.wready;
    assign inport1.wready = live_s & ~w_empty_s &  w_head_s & outport.wready;
    assign w_pop_s        = outport.wvalid & outport.wready & outport.wlast;

    assign inport0.bvalid = live_s & ~b_empty_s & ~b_head_s & outport.bvalid;
    assign inport1.bvalid = live_s & ~b_empty_s &  b_head_s & outport.bvalid;
    assign inport0.bresp  = outport.bresp;
    assign inport1.bresp  = outport.bresp;
    assign inport0.bid    = outport.bid;
    assign inport1.bid    = outport.bid;
    assign outport.bready = live_s & ~b_empty_s & (b_head_s ? inport1.bready : inport0.bready);
    assign b_pop_s        = outport.bvalid & outport.bready;

    assign inport0.rvalid = live_s & ~r_empty_s & ~r_head_s & outport.rvalid;
    assign inport1.rvalid = live_s & ~r_empty_s &  r_head_s & outport.rvalid;
    assign inport0.rdata  = outport.rdata;
    assign inport1.rdata  = outport.rdata;
    assign inport0.rresp  = outport.rresp;
    assign inport1.rresp  = outport.rresp;
    assign inport0.rid    = outport.rid;
    assign inport1.rid    = outport.rid;
    assign inport0.rlast  = outport.rlast;
    assign inport1.rlast  = outport.rlast;
    assign outport.rready = live_s & ~r_empty_s & (r_head_s ? inport1.rready : inport0.rready);
    assign r_pop_s        = outport.rvalid & outport.rready & outport.rlast;

    axi4_arb_route_fifo #(.ADDR_W(FIFO_ADDR_W), .DEPTH(OUTSTANDING_W)) u_w_route (
        .clk_i(clk_i), .rst_i(rst_i), .push(aw_fire_s), .push_data(aw_grant_s == PORT1),
        .pop(w_pop_s), .full(w_full_s), .empty(w_empty_s), .head(w_head_s)
    );

    axi4_arb_route_fifo #(.ADDR_W(FIFO_ADDR_W), .DEPTH(OUTSTANDING_W)) u_b_route (
        .clk_i(clk_i), .rst_i(rst_i), .push(aw_fire_s), .push_data(aw_grant_s == PORT1),
        .pop(b_pop_s), .full(b_full_s), .empty(b_empty_s), .head(b_head_s)
    );

    axi4_arb_route_fifo #(.ADDR_W(FIFO_ADDR_W), .DEPTH(OUTSTANDING_R)) u_r_route (
        .clk_i(clk_i), .rst_i(rst_i), .push(ar_fire_s), .push_data(ar_grant_s == PORT1),
        .pop(r_pop_s), .full(r_full_s), .empty(r_empty_s), .head(r_head_s)
    );

endmodule

// File: tb/tb_axi4_arb.sv
// Directed self-checking bench for axi4_arb; the bench plays both upstream masters and the slave.
module tb_axi4_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] p0d [4];
    logic [31:0] p1d [2];
    logic [31:0] wexp [6];

    always #5 clk = ~clk;

    axi4_arb_if in0 ();
    axi4_arb_if in1 ();
    axi4_arb_if out ();

    axi4_arb #(.OUTSTANDING_W(4), .OUTSTANDING_R(4), .FIFO_ADDR_W(2)) dut (
        .clk_i(clk), .rst_i(rst), .inport0(in0), .inport1(in1), .outport(out)
    );

    function automatic logic [14:0] all_outs();
        return {out.awvalid, out.wvalid, out.arvalid, out.bready, out.rready,
                in0.awready, in0.wready, in0.bvalid, in0.arready, in0.rvalid,
                in1.awready, in1.wready, in1.bvalid, in1.arready, in1.rvalid};
    endfunction

    task automatic idle();
        in0.awvalid = 1'b0; in0.awaddr = 32'h0; in0.awid = 4'h0; in0.awlen = 8'h0; in0.awburst = 2'b01;
        in0.wvalid = 1'b0; in0.wdata = 32'h0; in0.wstrb = 4'hF; in0.wlast = 1'b0; in0.bready = 1'b0;
        in0.arvalid = 1'b0; in0.araddr = 32'h0; in0.arid = 4'h0; in0.arlen = 8'h0; in0.arburst = 2'b01;
        in0.rready = 1'b0;
        in1.awvalid = 1'b0; in1.awaddr = 32'h0; in1.awid = 4'h0; in1.awlen = 8'h0; in1.awburst = 2'b01;
        in1.wvalid = 1'b0; in1.wdata = 32'h0; in1.wstrb = 4'hF; in1.wlast = 1'b0; in1.bready = 1'b0;
        in1.arvalid = 1'b0; in1.araddr = 32'h0; in1.arid = 4'h0; in1.arlen = 8'h0; in1.arburst = 2'b01;
        in1.rready = 1'b0;
        out.awready = 1'b0; out.wready = 1'b0; out.arready = 1'b0;
        out.bvalid = 1'b0; out.bresp = 2'b00; out.bid = 4'h0;
        out.rvalid = 1'b0; out.rdata = 32'h0; out.rresp = 2'b00; out.rid = 4'h0; out.rlast = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        to_sample();
        checks++;
        if (all_outs() !== 15'h0) begin
            failures++; $display("FAIL reset_outs act=%h exp=%h", all_outs(), 15'h0);
        end
        step();
        rst = 1'b0;
        to_sample();
        checks++;
        if (all_outs() !== 15'h0) begin
            failures++; $display("FAIL post_reset_outs act=%h exp=%h", all_outs(), 15'h0);
        end
        step();
    endtask

    task automatic test_single_write();
        in0.awvalid = 1'b1; in0.awaddr = 32'h1000; in0.awid = 4'h3; in0.awlen = 8'd3;
        out.awready = 1'b1;
        to_sample();
        checks++;
        if ({out.awvalid, out.awaddr} !== {1'b1, 32'h1000}) begin
            failures++; $display("FAIL sw_aw act=%b/%h exp=1/00001000", out.awvalid, out.awaddr);
        end
        checks++;
        if ({in1.awready, in0.awready} !== 2'b01) begin
            failures++; $display("FAIL sw_awready act=%b exp=01", {in1.awready, in0.awready});
        end
        step();
        in0.awvalid = 1'b0; out.awready = 1'b0; out.wready = 1'b1; in0.wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in0.wdata = 32'hD000_0000 + i;
            in0.wlast = (i == 3);
            to_sample();
            checks++;
            if ({out.wvalid, out.wdata} !== {1'b1, 32'hD000_0000 + i}) begin
                failures++; $display("FAIL sw_wbeat%0d act=%b/%h exp=1/%h", i, out.wvalid, out.wdata, 32'hD000_0000 + i);
            end
            checks++;
            if ({in1.wready, in0.wready} !== 2'b01) begin
                failures++; $display("FAIL sw_wready%0d act=%b exp=01", i, {in1.wready, in0.wready});
            end
            step();
        end
        in0.wvalid = 1'b0; in0.wlast = 1'b0; out.wready = 1'b0;
        out.bvalid = 1'b1; out.bresp = 2'b00; out.bid = 4'h3; in0.bready = 1'b1; in1.bready = 1'b0;
        to_sample();
        checks++;
        if ({in1.bvalid, in0.bvalid} !== 2'b01) begin
            failures++; $display("FAIL sw_bvalid act=%b exp=01", {in1.bvalid, in0.bvalid});
        end
        checks++;
        if ({in0.bresp, in0.bid} !== {2'b00, 4'h3}) begin
            failures++; $display("FAIL sw_bresp act=%h/%h exp=0/3", in0.bresp, in0.bid);
        end
        checks++;
        if (out.bready !== 1'b1) begin
            failures++; $display("FAIL sw_bready act=%b exp=1", out.bready);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_ar_contention();
        in0.arvalid = 1'b1; in0.arid = 4'h1; in0.araddr = 32'h100;
        in1.arvalid = 1'b1; in1.arid = 4'h2; in1.araddr = 32'h200;
        out.arready = 1'b1;
        to_sample();
        checks++;
        if ({out.arid, in1.arready, in0.arready} !== {4'h1, 2'b01}) begin
            failures++; $display("FAIL ar_first act=%h/%b exp=1/01", out.arid, {in1.arready, in0.arready});
        end
        step();
        in0.arvalid = 1'b0;
        to_sample();
        checks++;
        if ({out.arid, in1.arready, in0.arready} !== {4'h2, 2'b10}) begin
            failures++; $display("FAIL ar_second act=%h/%b exp=2/10", out.arid, {in1.arready, in0.arready});
        end
        step();
        in1.arvalid = 1'b0; out.arready = 1'b0;
        in0.rready = 1'b1; in1.rready = 1'b1; out.rvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            out.rid = (i < 2) ? 4'h1 : 4'h2;
            out.rdata = 32'h5000 + i;
            out.rlast = (i % 2 == 1);
            to_sample();
            checks++;
            if ({in1.rvalid, in0.rvalid} !== ((i < 2) ? 2'b01 : 2'b10)) begin
                failures++; $display("FAIL ar_rbeat%0d act=%b exp=%b", i, {in1.rvalid, in0.rvalid}, (i < 2) ? 2'b01 : 2'b10);
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_aw_lock();
        in1.awvalid = 1'b1; in1.awaddr = 32'h2000; in1.awid = 4'h5;
        out.awready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in0.awvalid = 1'b1; in0.awaddr = 32'h3000; in0.awid = 4'h6;
            end
            to_sample();
            checks++;
            if ({out.awvalid, out.awaddr, out.awid} !== {1'b1, 32'h2000, 4'h5}) begin
                failures++; $display("FAIL lock_hold%0d act=%b/%h/%h exp=1/00002000/5", i, out.awvalid, out.awaddr, out.awid);
            end
            step();
        end
        out.awready = 1'b1;
        to_sample();
        checks++;
        if ({out.awaddr, in1.awready, in0.awready} !== {32'h2000, 2'b10}) begin
            failures++; $display("FAIL lock_hs act=%h/%b exp=00002000/10", out.awaddr, {in1.awready, in0.awready});
        end
        step();
        in1.awvalid = 1'b0;
        to_sample();
        checks++;
        if ({out.awaddr, in1.awready, in0.awready} !== {32'h3000, 2'b01}) begin
            failures++; $display("FAIL lock_next act=%h/%b exp=00003000/01", out.awaddr, {in1.awready, in0.awready});
        end
        step();
        in0.awvalid = 1'b0; out.awready = 1'b0;
        in1.wvalid = 1'b1; in1.wdata = 32'hB1; in1.wlast = 1'b1;
        in0.wvalid = 1'b1; in0.wdata = 32'hA1; in0.wlast = 1'b1;
        out.wready = 1'b1;
        to_sample();
        checks++;
        if ({out.wdata, in1.wready, in0.wready} !== {32'hB1, 2'b10}) begin
            failures++; $display("FAIL lock_w1 act=%h/%b exp=000000b1/10", out.wdata, {in1.wready, in0.wready});
        end
        step();
        in1.wvalid = 1'b0;
        to_sample();
        checks++;
        if ({out.wdata, in1.wready, in0.wready} !== {32'hA1, 2'b01}) begin
            failures++; $display("FAIL lock_w2 act=%h/%b exp=000000a1/01", out.wdata, {in1.wready, in0.wready});
        end
        step();
        idle();
        out.bvalid = 1'b1; out.bid = 4'h5; in0.bready = 1'b1; in1.bready = 1'b1;
        to_sample();
        checks++;
        if ({in1.bvalid, in0.bvalid, in1.bid} !== {2'b10, 4'h5}) begin
            failures++; $display("FAIL lock_b1 act=%b/%h exp=10/5", {in1.bvalid, in0.bvalid}, in1.bid);
        end
        step();
        out.bid = 4'h6;
        to_sample();
        checks++;
        if ({in1.bvalid, in0.bvalid, in0.bid} !== {2'b01, 4'h6}) begin
            failures++; $display("FAIL lock_b2 act=%b/%h exp=01/6", {in1.bvalid, in0.bvalid}, in0.bid);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_ar_full();
        out.arready = 1'b1; in0.arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in0.arid = 4'(i);
            to_sample();
            checks++;
            if ({out.arvalid, in0.arready} !== 2'b11) begin
                failures++; $display("FAIL full_ar%0d act=%b exp=11", i, {out.arvalid, in0.arready});
            end
            step();
        end
        in0.arid = 4'h4;
        to_sample();
        checks++;
        if ({out.arvalid, in0.arready} !== 2'b00) begin
            failures++; $display("FAIL full_stall act=%b exp=00", {out.arvalid, in0.arready});
        end
        step();
        out.rvalid = 1'b1; out.rlast = 1'b1; out.rid = 4'h0; in0.rready = 1'b1;
        to_sample();
        checks++;
        if ({out.arvalid, in0.rvalid} !== 2'b01) begin
            failures++; $display("FAIL full_pop_cycle act=%b exp=01", {out.arvalid, in0.rvalid});
        end
        step();
        out.rvalid = 1'b0;
        to_sample();
        checks++;
        if ({out.arvalid, out.arid} !== {1'b1, 4'h4}) begin
            failures++; $display("FAIL full_release act=%b/%h exp=1/4", out.arvalid, out.arid);
        end
        step();
        in0.arvalid = 1'b0; out.arready = 1'b0; out.rvalid = 1'b1;
        for (int i = 1; i < 5; i++) begin
            out.rid = 4'(i);
            to_sample();
            checks++;
            if ({in0.rvalid, out.rready} !== 2'b11) begin
                failures++; $display("FAIL full_drain%0d act=%b exp=11", i, {in0.rvalid, out.rready});
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_interleave();
        int idx0 = 0;
        int idx1 = 0;
        int k = 0;
        logic acc0, acc1;
        p0d = '{32'hA0, 32'hA1, 32'hC0, 32'hC1};
        p1d = '{32'hB0, 32'hB1};
        wexp = '{32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hC0, 32'hC1};
        out.awready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in0.awvalid = (i != 1); in0.awid = 4'(i + 1); in0.awlen = 8'd1;
            in1.awvalid = (i == 1); in1.awid = 4'(i + 1); in1.awlen = 8'd1;
            to_sample();
            checks++;
            if ({out.awid, in1.awready, in0.awready} !== {4'(i + 1), (i == 1), (i != 1)}) begin
                failures++; $display("FAIL il_aw%0d act=%h/%b exp=%h", i, out.awid, {in1.awready, in0.awready}, i + 1);
            end
            step();
        end
        idle();
        for (int c = 0; c < 16; c++) begin
            out.wready = c[0];
            in0.wvalid = (idx0 < 4); in0.wdata = (idx0 < 4) ? p0d[idx0] : 32'h0; in0.wlast = (idx0 % 2 == 1);
            in1.wvalid = (idx1 < 2); in1.wdata = (idx1 < 2) ? p1d[idx1] : 32'h0; in1.wlast = (idx1 % 2 == 1);
            to_sample();
            if (out.wvalid && out.wready) begin
                checks++;
                if (k >= 6 || out.wdata !== wexp[k]) begin
                    failures++; $display("FAIL il_wbeat%0d act=%h exp=%h", k, out.wdata, (k < 6) ? wexp[k] : 32'h0);
                end
                k++;
            end
            acc0 = in0.wvalid & in0.wready;
            acc1 = in1.wvalid & in1.wready;
            step();
            idx0 += int'(acc0);
            idx1 += int'(acc1);
        end
        checks++;
        if (k !== 6) begin
            failures++; $display("FAIL il_wcount act=%0d exp=6", k);
        end
        idle();
        in0.bready = 1'b1; in1.bready = 1'b1; out.bvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out.bid = 4'(i + 1);
            out.bresp = (i == 1) ? 2'b01 : 2'b00;
            to_sample();
            checks++;
            if ({in1.bvalid, in0.bvalid} !== ((i == 1) ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL il_broute%0d act=%b exp=%b", i, {in1.bvalid, in0.bvalid}, (i == 1) ? 2'b10 : 2'b01);
            end
            checks++;
            if ((i == 1 ? {in1.bid, in1.bresp} : {in0.bid, in0.bresp}) !== {4'(i + 1), (i == 1) ? 2'b01 : 2'b00}) begin
                failures++; $display("FAIL il_bid%0d act=%h exp=%h", i, (i == 1) ? in1.bid : in0.bid, i + 1);
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_reset_midburst();
        in0.awvalid = 1'b1; in0.awaddr = 32'h4000; in0.awid = 4'h7; in0.awlen = 8'd1; out.awready = 1'b1;
        in1.arvalid = 1'b1; in1.arid = 4'h9; out.arready = 1'b1;
        step();
        in0.awvalid = 1'b0; in1.arvalid = 1'b0;
        in0.wvalid = 1'b1; in0.wdata = 32'h77; in0.wlast = 1'b0; out.wready = 1'b1;
        out.rvalid = 1'b1; out.rid = 4'h9; out.rlast = 1'b0; in1.rready = 1'b1;
        to_sample();
        checks++;
        if ({out.wvalid, in1.rvalid} !== 2'b11) begin
            failures++; $display("FAIL rst_pre act=%b exp=11", {out.wvalid, in1.rvalid});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (all_outs() !== 15'h0) begin
            failures++; $display("FAIL rst_async act=%h exp=%h", all_outs(), 15'h0);
        end
        idle();
        step();
        rst = 1'b0;
        in0.awvalid = 1'b1; in0.awaddr = 32'h5000;
        in1.awvalid = 1'b1; in1.awaddr = 32'h6000;
        out.awready = 1'b1;
        to_sample();
        checks++;
        if ({out.awaddr, in1.awready, in0.awready} !== {32'h5000, 2'b01}) begin
            failures++; $display("FAIL rst_first act=%h/%b exp=00005000/01", out.awaddr, {in1.awready, in0.awready});
        end
        step();
        in0.awvalid = 1'b0;
        to_sample();
        checks++;
        if ({out.awaddr, in1.awready, in0.awready} !== {32'h6000, 2'b10}) begin
            failures++; $display("FAIL rst_second act=%h/%b exp=00006000/10", out.awaddr, {in1.awready, in0.awready});
        end
        step();
        idle();
        step();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_write();
        test_ar_contention();
        test_aw_lock();
        test_ar_full();
        test_interleave();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
